// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and constants for the MIPS memory-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Read data returned to a master whose transfer was killed by the watchdog
  localparam logic [31:0] TIMEOUT_READDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mips_bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_rr_pick
// Description : Combinational two-way round-robin picker. On a tie the
//               master that was not served last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_rr_pick
  import mips_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] winner
);

  // One-hot winner; a lone requester always wins, ties go against last_served
  always_comb begin
    winner = GRANT_NONE;
    case (req)
      2'b01:   winner = GRANT_M0;
      2'b10:   winner = GRANT_M1;
      2'b11:   winner = last_served ? GRANT_M0 : GRANT_M1;
      default: winner = GRANT_NONE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Two-master / one-slave Avalon-style bus arbiter. m0 is the
//               instruction fetch port, m1 the load/store port. The grant is
//               held for a whole transfer including waitrequest stalls.
//               Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant,
  output logic                timeout_error
);

  arb_state_t state_q, state_d;
  logic       last_served_q, last_served_d;
  logic [1:0] req;
  logic [1:0] pick;
  logic       expire;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  mips_bus_rr_pick u_rr_pick (
    .req         (req),
    .last_served (last_served_q),
    .winner      (pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;

  assign expire        = (state_q != IDLE) && (stall_q == STALL_LIMIT);
  assign timeout_error = timeout_q;

  // Stall counter: counts only while the same owner keeps stalling; any grant,
  // completion or release clears it. The error flag is sticky.
  always_comb begin
    stall_d   = '0;
    timeout_d = timeout_q | expire;
    if ((state_q != IDLE) && (state_d == state_q) && s_waitrequest && !expire) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
  assign timeout_error  = 1'b0;
`endif

  // Slave-side mux driven by the registered owner; read wins over write
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    grant          = GRANT_NONE;
    case (state_q)
      OWN0: begin
        grant = GRANT_M0;
        if (expire) begin
          m0_waitrequest = 1'b0;
          m0_readdata    = DATA_W'(TIMEOUT_READDATA);
        end else begin
          s_address      = m0_address;
          s_read         = m0_read;
          s_write        = m0_write & ~m0_read;
          s_byteenable   = m0_byteenable;
          s_writedata    = m0_writedata;
          m0_waitrequest = s_waitrequest;
        end
      end
      OWN1: begin
        grant = GRANT_M1;
        if (expire) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = DATA_W'(TIMEOUT_READDATA);
        end else begin
          s_address      = m1_address;
          s_read         = m1_read;
          s_write        = m1_write & ~m1_read;
          s_byteenable   = m1_byteenable;
          s_writedata    = m1_writedata;
          m1_waitrequest = s_waitrequest;
        end
      end
      default: ;
    endcase
  end

  // Next-state: completion hands over to a waiting peer, otherwise keeps owner
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (pick == GRANT_M0)      state_d = OWN0;
        else if (pick == GRANT_M1) state_d = OWN1;
      end
      OWN0: begin
        if (expire || !req[0]) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_served_d = 1'b0;
          state_d       = req[1] ? OWN1 : OWN0;
        end
      end
      OWN1: begin
        if (expire || !req[1]) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_served_d = 1'b1;
          state_d       = req[0] ? OWN0 : OWN1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; last_served resets to m1 so m0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Self-checking bench for mips_bus_arbiter: RAM slave model,
//               reference memory, scoreboard queues and a cycle monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } txn_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout_error;

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  // ---------------- RAM slave model ----------------
  // wait_mode: 0 zero-wait, 1 random (max 2 stalls), 2 exactly 2 stalls, 3 stuck
  int          wait_mode = 0;
  int          stall_cnt = 0;
  logic        rnd_bit   = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem [0:255];

  function automatic logic [31:0] init_val(input int idx);
    return (idx == 0) ? 32'h2402_0005 : (32'h5A5A_0000 ^ (idx * 32'h0001_0203));
  endfunction

  always @(posedge clk) begin
    rnd_bit <= ($urandom_range(0, 1) == 1);
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (s_write && !s_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[9:2]][b*8 +: 8] <= s_writedata[b*8 +: 8];
    end
    if ((s_read || s_write) && s_waitrequest) stall_cnt <= stall_cnt + 1;
    else                                      stall_cnt <= 0;
  end

  assign s_waitrequest = (wait_mode == 0) ? 1'b0 :
                         (wait_mode == 1) ? (rnd_bit && (stall_cnt < 2)) :
                         (wait_mode == 2) ? (stall_cnt < 2) : 1'b1;
  assign s_readdata = mem[s_address[9:2]];

  // ---------------- reference memory ----------------
  logic [31:0] ref_w [int];

  function automatic logic [31:0] ref_rd(input int idx);
    return ref_w.exists(idx) ? ref_w[idx] : init_val(idx);
  endfunction

  task automatic ref_wr(input int idx, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] v;
    v = ref_rd(idx);
    for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = d[b*8 +: 8];
    ref_w[idx] = v;
  endtask

  // ---------------- scoreboard ----------------
  txn_t       mq0[$], mq1[$], sq0[$], sq1[$];
  logic [1:0] glog[$];
  int         clog[$];
  int         wcount = 0;
  int         cyc    = 0;
  bit         sb_en  = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  function automatic logic [1:0] glog_at(input int k);
    return (k < glog.size()) ? glog[k] : 2'b11;
  endfunction

  task automatic cmp_slave(input txn_t t);
    chkb("s_read", s_read, t.rd);
    chkb("s_write", s_write, t.wr);
    chk("s_address", s_address, t.addr);
    chk("s_byteenable", 32'(s_byteenable), 32'(t.be));
    if (t.wr) chk("s_writedata", s_writedata, t.data);
  endtask

  task automatic monitor();
    txn_t t;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chkb("rw_exclusive", s_read && s_write, 1'b0);
        chkb("grant_legal", grant != 2'b11, 1'b1);
        if (grant != 2'b01) chkb("m0_wait_nonowner", m0_waitrequest, 1'b1);
        if (grant != 2'b10) chkb("m1_wait_nonowner", m1_waitrequest, 1'b1);
        if (grant == 2'b00) chkb("idle_strobe", s_read || s_write, 1'b0);
`ifndef ARB_TIMEOUT_EN
        chk("m0_rdata_copy", m0_readdata, s_readdata);
        chk("m1_rdata_copy", m1_readdata, s_readdata);
        chkb("timeout_tied", timeout_error, 1'b0);
`endif
        if (sb_en) begin
          if ((s_read || s_write) && !s_waitrequest) begin
            glog.push_back(grant);
            clog.push_back(cyc);
            if (s_write) wcount++;
            if (grant == 2'b01 && sq0.size() > 0) begin
              t = sq0.pop_front(); cmp_slave(t);
            end else if (grant == 2'b10 && sq1.size() > 0) begin
              t = sq1.pop_front(); cmp_slave(t);
            end else begin
              checks++; errors++;
              $display("FAIL slave_unexpected: grant %b with no pending transfer, required a pending transfer", grant);
            end
          end
          if ((m0_read || m0_write) && !m0_waitrequest) begin
            if (mq0.size() > 0) begin
              t = mq0.pop_front();
              if (t.rd) chk("m0_readdata", m0_readdata, t.data);
            end else begin
              checks++; errors++;
              $display("FAIL m0_unexpected: completion with empty queue, required none");
            end
          end
          if ((m1_read || m1_write) && !m1_waitrequest) begin
            if (mq1.size() > 0) begin
              t = mq1.pop_front();
              if (t.rd) chk("m1_readdata", m1_readdata, t.data);
            end else begin
              checks++; errors++;
              $display("FAIL m1_unexpected: completion with empty queue, required none");
            end
          end
        end
      end
    end
  endtask

  // ---------------- master drivers ----------------
  task automatic drop_req(input int id);
    if (id == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
    else         begin m1_read = 1'b0; m1_write = 1'b0; end
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One transfer; returns at #1 after the completion edge with request still up
  task automatic xfer(input int id, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd);
    txn_t m, s;
    int   idx;
    bit   done;
    idx    = int'(addr[9:2]);
    m.rd   = rd; m.wr = wr; m.addr = addr; m.be = be;
    m.data = rd ? ref_rd(idx) : 32'd0;
    s.rd   = rd; s.wr = wr && !rd; s.addr = addr; s.be = be; s.data = wd;
    if (wr && !rd) ref_wr(idx, be, wd);
    if (id == 0) begin
      mq0.push_back(m); sq0.push_back(s);
      m0_address = addr; m0_read = rd; m0_write = wr; m0_byteenable = be; m0_writedata = wd;
    end else begin
      mq1.push_back(m); sq1.push_back(s);
      m1_address = addr; m1_read = rd; m1_write = wr; m1_byteenable = be; m1_writedata = wd;
    end
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (((id == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_bound: master %0d stalled 200 cycles, required completion", id);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_master(input int id, input int n);
    for (int i = 0; i < n; i++) begin
      int          r, g;
      logic [31:0] a;
      r = int'($urandom_range(0, 7));
      if (id == 0) begin
        a = 32'($urandom_range(0, 63)) << 2;
        xfer(0, 1'b1, 1'b0, a, 4'hF, 32'd0);
      end else begin
        a = 32'(128 + $urandom_range(0, 63)) << 2;
        xfer(1, (r < 4), (r == 0) || (r >= 4), a, 4'($urandom_range(0, 15)), $urandom);
      end
      g = int'($urandom_range(0, 2));
      if (g > 0) begin drop_req(id); gap(g); end
    end
    drop_req(id);
  endtask

  task automatic do_reset();
    drop_req(0); drop_req(1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    fork monitor(); join_none
    #1 reset = 1'b0;
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chkb("rst_s_read", s_read, 1'b0);
    chkb("rst_s_write", s_write, 1'b0);
    chk("rst_s_address", s_address, 32'd0);
    chkb("rst_m0_wait", m0_waitrequest, 1'b1);
    chkb("rst_m1_wait", m1_waitrequest, 1'b1);
    chkb("rst_timeout", timeout_error, 1'b0);
    do_reset();

    // Reset mid-transfer
    wait_mode = 3;
    m0_address = 32'h0; m0_read = 1'b1;
    @(negedge clk); chk("midrst_pre_grant", 32'(grant), 32'd0);
    @(negedge clk); chkb("midrst_s_read", s_read, 1'b1); chk("midrst_grant", 32'(grant), 32'd1);
    #2 reset = 1'b0;
    #1;
    chkb("midrst_s_read_async", s_read, 1'b0);
    chk("midrst_grant_async", 32'(grant), 32'd0);
    chkb("midrst_m0_wait", m0_waitrequest, 1'b1);
    chkb("midrst_m1_wait", m1_waitrequest, 1'b1);
    chkb("midrst_timeout", timeout_error, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    wait_mode = 0;
    @(negedge clk); chk("midrst_still_idle", 32'(grant), 32'd0);
    @(negedge clk); chk("midrst_regrant", 32'(grant), 32'd1);
    @(posedge clk); #1 drop_req(0);
    gap(2);

    // Single fetch with 2 stall cycles
    do_reset();
    wait_mode = 2;
    m0_address = 32'hBFC0_0000; m0_read = 1'b1;
    @(negedge clk); chkb("fetch_lat_idle", s_read, 1'b0);
    @(negedge clk);
    chkb("fetch_s_read", s_read, 1'b1);
    chk("fetch_s_addr", s_address, 32'hBFC0_0000);
    chkb("fetch_wait_mirror", m0_waitrequest, s_waitrequest);
    chkb("fetch_stall1", m0_waitrequest, 1'b1);
    @(negedge clk); chkb("fetch_stall2", m0_waitrequest, 1'b1);
    @(negedge clk);
    chkb("fetch_done", m0_waitrequest, 1'b0);
    chk("fetch_rdata", m0_readdata, 32'h2402_0005);
    chkb("fetch_m1_wait", m1_waitrequest, 1'b1);
    @(posedge clk); #1 drop_req(0);
    gap(2);

    // Contention: m0 first, m1 back-to-back
    do_reset();
    wait_mode = 0; glog.delete(); clog.delete(); wcount = 0; sb_en = 1'b1;
    fork
      begin xfer(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'd0); drop_req(0); end
      begin xfer(1, 1'b0, 1'b1, 32'h1000, 4'b0011, 32'h0000_ABCD); drop_req(1); end
    join
    gap(3);
    chk("cont_first", 32'(glog_at(0)), 32'd1);
    chk("cont_second", 32'(glog_at(1)), 32'd2);
    chk("cont_no_idle", (clog.size() >= 2) ? 32'(clog[1] - clog[0]) : 32'hFFFF_FFFF, 32'd1);
    chk("cont_one_write", 32'(wcount), 32'd1);

    // Fairness: 6 back-to-back transfers alternate
    do_reset();
    glog.delete(); clog.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) xfer(0, 1'b1, 1'b0, 32'(4 * (10 + i)), 4'hF, 32'd0);
        drop_req(0);
      end
      begin
        for (int j = 0; j < 3; j++) xfer(1, 1'b1, 1'b0, 32'(32'h200 + 4 * j), 4'hF, 32'd0);
        drop_req(1);
      end
    join
    gap(3);
    chk("fair_count", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("fair_seq", 32'(glog_at(k)), (k % 2 == 0) ? 32'd1 : 32'd2);

    // Read and write together: read wins, write never lands
    do_reset();
    xfer(0, 1'b1, 1'b1, 32'h8, 4'hF, 32'h1234_5678); drop_req(0); gap(1);
    xfer(0, 1'b1, 1'b0, 32'h8, 4'hF, 32'd0); drop_req(0); gap(2);

    // Randomized traffic on both masters
    do_reset();
    wait_mode = 1;
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    gap(5);
    chk("sb_drain", 32'(mq0.size() + mq1.size() + sq0.size() + sq1.size()), 32'd0);
    sb_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Watchdog with TIMEOUT_CYCLES = 4
    do_reset();
    wait_mode = 3;
    m0_address = 32'h0; m0_read = 1'b1;
    @(negedge clk); chk("to_idle", 32'(grant), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chkb("to_stall", m0_waitrequest, 1'b1);
    end
    @(negedge clk);
    chkb("to_forced", m0_waitrequest, 1'b0);
    chk("to_rdata", m0_readdata, 32'hDEAD_BEEF);
    chkb("to_err_pre", timeout_error, 1'b0);
    @(posedge clk); #1 drop_req(0);
    @(negedge clk);
    chk("to_back_idle", 32'(grant), 32'd0);
    chkb("to_err_set", timeout_error, 1'b1);
    repeat (3) @(negedge clk);
    chkb("to_err_sticky", timeout_error, 1'b1);
    #1 reset = 1'b0;
    #1 chkb("to_err_cleared", timeout_error, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
`endif

    gap(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
